// File: rtl/pipo_loader_pkg.sv
// Shared types and helpers for the round-robin PIPO loader.
// The holding state is encoded directly by q_valid.
package pipo_loader_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipo_rr_arb.sv
// Combinational round-robin arbiter.
// The search starts at ptr_i and wraps past NREQ-1.
module pipo_rr_arb
  import pipo_loader_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [SRCW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [SRCW-1:0] grant_idx_o
);

  logic            found;
  logic [SRCW:0]   sum;
  logic [SRCW-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (SRCW+1)'(k);
      if (sum >= (SRCW+1)'(NREQ)) begin
        sum = sum - (SRCW+1)'(NREQ);
      end
      idx = sum[SRCW-1:0];
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        grant_o     = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/pipo_rr_loader.sv
// Round-robin loader sharing one PIPO holding register.
// Drain and load may happen in the same cycle for full throughput.
module pipo_rr_loader
  import pipo_loader_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [clog2_min1(NREQ)-1:0] q_src,
  input  logic                    q_ready
);

  localparam int SRCW = clog2_min1(NREQ);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SRCW-1:0] src_q, src_d;
  logic [SRCW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] grant;
  logic [SRCW-1:0] grant_idx;
  logic            accept;

  pipo_rr_arb #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign accept = rstn
                & ((state_q == EMPTY) | q_ready)
                & (|req_valid);

  assign req_ready = accept ? grant : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = FULL;
      data_d  = req_data[grant_idx*WIDTH +: WIDTH];
      src_d   = grant_idx;
      ptr_d   = (grant_idx == SRCW'(NREQ-1))
              ? '0 : grant_idx + SRCW'(1);
    end else if (state_q == FULL && q_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign q       = data_q;
  assign q_src   = src_q;
  assign q_valid = (state_q == FULL);

endmodule

// File: doc/pipo_rr_loader.md
Name: pipo_rr_loader

Overview:
Shares one parallel-in/parallel-out holding register between NREQ requesters using round-robin arbitration. Each requester presents a word with a valid/ready handshake. The winner's word is loaded into the register and presented downstream with its source ID under a second valid/ready handshake. The block sits between multiple producers and a single consumer of the existing PIPO-style register datapath.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 4, data word width in bits
SRCW, max(1, clog2(NREQ)), derived; width of source ID (localparam, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  reset, synchronous, active-low
req_valid  input  NREQ  bit i: requester i has a word pending
req_data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  bit i: requester i's word is accepted this cycle
q  output  WIDTH  held register value
q_valid  output  1  q holds an unconsumed word
q_src  output  SRCW  index of the requester whose word is in q
q_ready  input  1  consumer takes q this cycle when q_valid=1

Behaviour:
- Reset (rstn=0 at a clk edge): q=0, q_valid=0, q_src=0, rr pointer ptr=0. While rstn=0, req_ready=0 regardless of inputs. A reset mid-transfer discards the held word.
- States, encoded by q_valid: EMPTY (q_valid=0), FULL (q_valid=1).
- accept = rstn && (!q_valid || q_ready) && |req_valid. Combinational path from q_ready to req_ready is intended.
- Grant: first i with req_valid[i]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1. One-hot, at most one bit set.
- req_ready = grant one-hot when accept=1, else all zero.
- On accept edge: q <= winner data, q_src <= winner index, q_valid <= 1, ptr <= (winner+1) mod NREQ.
- FULL with q_ready=1 and no req_valid: q_valid <= 0. q and q_src retain their old values.
- FULL with q_ready=0: all outputs hold, req_ready=0, ptr unchanged.
- Simultaneous drain and load (FULL, q_ready=1, request present): new word loads in the same cycle. This gives zero-bubble throughput of 1 word/cycle.
- Latency: word visible on q one cycle after its accept edge.
- ptr changes only on accept. Idle cycles do not advance it.
- Requesters must hold req_valid/req_data stable until req_ready. The block does not check this.
- Lowering req_valid before grant is allowed and simply removes the request.
- Fairness: a continuously asserting requester waits at most NREQ-1 accepts.

Decomposition:
- Package pipo_loader_pkg: state encoding constants (EMPTY/FULL), function clog2_min1 for SRCW.
- One sub-module: pipo_rr_arb. Combinational round-robin arbiter with inputs req[NREQ] and ptr[SRCW], outputs grant one-hot and grant_idx. Top level holds ptr, q, q_src and q_valid.

Test Plan:
- Reset: rstn=0 for 2 cycles with req_valid=4'b1111, q_ready=1. Required: req_ready=0 throughout; after release, q=0, q_valid=0, q_src=0.
- Single load: req_valid=4'b0100, req_data word2=4'b1011, q_ready=0 from EMPTY. Required: req_ready=4'b0100 for that cycle; next cycle q=4'b1011, q_src=2, q_valid=1; following cycles req_ready=0.
- Round-robin: req_valid=4'b1111 held, words 4'h1/4'h2/4'h3/4'h4, q_ready=1. Required: q_src sequence 0,1,2,3,0,1 on consecutive cycles, q_valid stays 1, no bubbles.
- Backpressure: FULL with q=4'hA, q_ready=0, req_valid=4'b0010 for 3 cycles. Required: req_ready=0, q=4'hA held. Then q_ready=1: req_ready=4'b0010 the same cycle, next cycle q=requester 1 word, q_src=1.
- Drain: FULL q=4'h5, q_ready=1, req_valid=0. Required: next cycle q_valid=0, q=4'h5 unchanged; ptr unchanged, confirmed by the next grant order.
- Reset mid-operation: FULL with pending requests, pulse rstn=0 for one cycle. Required: q=0, q_valid=0, ptr=0, so the next grant goes to the lowest-indexed valid requester.
